// File: rtl/room_occupancy_ctrl.sv
// rtl/room_occupancy_ctrl.sv - door crossing decoder driving the room occupancy counter
module room_occupancy_ctrl #(
    parameter int CAPACITY = 15,
    parameter int WIDTH    = 4,
    parameter int TIMEOUT  = 1000,
    parameter int TIMER_W  = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sens_a,
    input  logic             sens_b,
    input  logic [WIDTH-1:0] number,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             reject,
    output logic             fault,
    output logic             full,
    output logic             empty,
    output logic             light
);

    typedef enum logic [2:0] {
        IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, ABORT
    } state_t;

    localparam logic [TIMER_W-1:0] TIMEOUT_V  = TIMER_W'(TIMEOUT);
    localparam logic [WIDTH-1:0]   CAPACITY_V = WIDTH'(CAPACITY);

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               a_m, a_s, b_m, b_s;
    logic [1:0]         ab;
    logic               commit_ent, commit_ext;

    assign full  = (number >= CAPACITY_V);
    assign empty = (number == '0);
    assign light = ~empty;
    assign ab    = {a_s, b_s};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_m    <= 1'b0;
            a_s    <= 1'b0;
            b_m    <= 1'b0;
            b_s    <= 1'b0;
            state  <= IDLE;
            timer  <= '0;
            cnt_en <= 1'b0;
            cnt_up <= 1'b0;
            reject <= 1'b0;
            fault  <= 1'b0;
        end else begin
            a_m    <= sens_a;
            a_s    <= a_m;
            b_m    <= sens_b;
            b_s    <= b_m;
            state  <= state_next;
            timer  <= timer_next;
            cnt_en <= (commit_ent & ~full) | (commit_ext & ~empty);
            reject <= (commit_ent & full) | (commit_ext & empty);
            fault  <= (state_next == ABORT);
            // Direction only moves on an accepted commit; rejects leave it alone.
            if (commit_ent && !full)
                cnt_up <= 1'b1;
            else if (commit_ext && !empty)
                cnt_up <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        commit_ent = 1'b0;
        commit_ext = 1'b0;
        timer_next = '0;
        case (state)
            IDLE: case (ab)
                2'b10:   state_next = ENT1;
                2'b01:   state_next = EXT1;
                2'b11:   state_next = ABORT;
                default: state_next = IDLE;
            endcase
            ENT1: case (ab)
                2'b11:   state_next = ENT2;
                2'b00:   state_next = IDLE;
                2'b01:   state_next = ABORT;
                default: state_next = ENT1;
            endcase
            ENT2: case (ab)
                2'b01:   state_next = ENT3;
                2'b10:   state_next = ENT1;
                2'b00:   state_next = ABORT;
                default: state_next = ENT2;
            endcase
            ENT3: case (ab)
                2'b11:   state_next = ENT2;
                2'b10:   state_next = ABORT;
                2'b00: begin
                    state_next = IDLE;
                    commit_ent = 1'b1;
                end
                default: state_next = ENT3;
            endcase
            EXT1: case (ab)
                2'b11:   state_next = EXT2;
                2'b00:   state_next = IDLE;
                2'b10:   state_next = ABORT;
                default: state_next = EXT1;
            endcase
            EXT2: case (ab)
                2'b10:   state_next = EXT3;
                2'b01:   state_next = EXT1;
                2'b00:   state_next = ABORT;
                default: state_next = EXT2;
            endcase
            EXT3: case (ab)
                2'b11:   state_next = EXT2;
                2'b01:   state_next = ABORT;
                2'b00: begin
                    state_next = IDLE;
                    commit_ext = 1'b1;
                end
                default: state_next = EXT3;
            endcase
            default: state_next = (ab == 2'b00) ? IDLE : ABORT;
        endcase

        // A crossing that sits still too long is abandoned; any real step resets the clock.
        if (state != IDLE && state != ABORT && state_next == state && timer == TIMEOUT_V)
            state_next = ABORT;

        if (state_next == state && state != IDLE && state != ABORT)
            timer_next = timer + 1'b1;
    end

endmodule

// File: tb/tb_room_occupancy_ctrl.sv
// tb/tb_room_occupancy_ctrl.sv - table-driven scoreboard bench for room_occupancy_ctrl
module tb_room_occupancy_ctrl;

    localparam int TIMEOUT = 1000;
    localparam int K_ENT = 0, K_EXT = 1, K_BACK = 2;
    localparam int EV_INC = 1, EV_DEC = 2, EV_REJ = 3, EV_BOTH = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sens_a = 1'b0, sens_b = 1'b0;
    logic [3:0] number;
    logic       cnt_en, cnt_up, reject, fault, full, empty, light;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];

    typedef struct {
        int kind;
        int ev;
        int num;
        int up;
    } vec_t;
    vec_t vecs[$];

    room_occupancy_ctrl #(.CAPACITY(15), .WIDTH(4), .TIMEOUT(TIMEOUT), .TIMER_W(10)) dut (
        .clk(clk), .clr(clr), .sens_a(sens_a), .sens_b(sens_b), .number(number),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .reject(reject), .fault(fault),
        .full(full), .empty(empty), .light(light)
    );

    always #5 clk = ~clk;

    // Behavioural occupancy counter sharing the controller's reset.
    always @(posedge clk or negedge clr) begin
        if (!clr)
            number <= 4'd0;
        else if (cnt_en)
            number <= cnt_up ? number + 4'd1 : number - 4'd1;
    end

    always @(negedge clk) begin
        if (cnt_en === 1'b1 && reject === 1'b1) obs_q.push_back(EV_BOTH);
        else if (reject === 1'b1)               obs_q.push_back(EV_REJ);
        else if (cnt_en === 1'b1)               obs_q.push_back(cnt_up ? EV_INC : EV_DEC);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [1:0] v, input int cycles);
        {sens_a, sens_b} = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic crossing(input int kind);
        logic [1:0] seq [4];
        case (kind)
            K_ENT:   seq = '{2'b10, 2'b11, 2'b01, 2'b00};
            K_EXT:   seq = '{2'b01, 2'b11, 2'b10, 2'b00};
            default: seq = '{2'b10, 2'b11, 2'b10, 2'b00};
        endcase
        for (int i = 0; i < 4; i++) drive(seq[i], 4);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_events(input string name);
        check({name, "_evcount"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({name, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input int num, input int up);
        check({name, "_number"}, int'(number), num);
        check({name, "_full"},   int'(full),   (num >= 15) ? 1 : 0);
        check({name, "_empty"},  int'(empty),  (num == 0) ? 1 : 0);
        check({name, "_light"},  int'(light),  (num != 0) ? 1 : 0);
        check({name, "_cnt_up"}, int'(cnt_up), up);
        check({name, "_fault"},  int'(fault),  0);
    endtask

    task automatic add_vec(input int kind, input int ev, input int num, input int up);
        vec_t v;
        v.kind = kind; v.ev = ev; v.num = num; v.up = up;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(K_EXT,  EV_DEC, 0, 0);
        add_vec(K_EXT,  EV_REJ, 0, 0);
        add_vec(K_ENT,  EV_INC, 1, 1);
        add_vec(K_ENT,  EV_INC, 2, 1);
        add_vec(K_ENT,  EV_INC, 3, 1);
        add_vec(K_EXT,  EV_DEC, 2, 0);
        add_vec(K_BACK, 0,      2, 0);
        for (int n = 3; n <= 15; n++) add_vec(K_ENT, EV_INC, n, 1);
        add_vec(K_ENT,  EV_REJ, 15, 1);
        add_vec(K_BACK, 0,      15, 1);

        repeat (3) @(negedge clk);
        #1;
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_fault",  int'(fault),  0);
        check("rst_cnt_up", int'(cnt_up), 0);
        check("rst_empty",  int'(empty),  1);
        check("rst_light",  int'(light),  0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // First entry by hand to pin down commit latency.
        drive(2'b10, 4);
        drive(2'b11, 4);
        drive(2'b01, 4);
        {sens_a, sens_b} = 2'b00;
        exp_q.push_back(EV_INC);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("lat_cnt_en_c%0d", c + 1), int'(cnt_en), (c == 2) ? 1 : 0);
        end
        repeat (4) @(negedge clk);
        check_events("entry1");
        check_status("entry1", 1, 1);

        foreach (vecs[i]) begin
            if (vecs[i].ev != 0) exp_q.push_back(vecs[i].ev);
            crossing(vecs[i].kind);
            check_events($sformatf("vec%0d", i));
            check_status($sformatf("vec%0d", i), vecs[i].num, vecs[i].up);
        end

        // Stalled crossing must time out into ABORT.
        drive(2'b10, TIMEOUT + 5);
        check("timeout_fault", int'(fault), 1);
        drive(2'b00, 2);
        check("abort_hold_fault", int'(fault), 1);
        @(negedge clk);
        check("abort_exit_fault", int'(fault), 0);
        repeat (4) @(negedge clk);
        check_events("timeout");

        drive(2'b11, 4);
        check("illegal_fault", int'(fault), 1);
        drive(2'b00, 4);
        check("illegal_exit_fault", int'(fault), 0);
        check_events("illegal");
        check_status("illegal", 15, 1);

        // Reset in the middle of an entry drops the pending commit.
        drive(2'b10, 4);
        drive(2'b11, 4);
        drive(2'b01, 3);
        clr = 1'b0;
        #1;
        check("midrst_cnt_up", int'(cnt_up), 0);
        check("midrst_fault",  int'(fault),  0);
        @(negedge clk);
        @(negedge clk);
        {sens_a, sens_b} = 2'b00;
        clr = 1'b1;
        repeat (10) @(negedge clk);
        check_events("midrst");
        check("midrst_cnt_en", int'(cnt_en), 0);
        check("midrst_reject", int'(reject), 0);
        check_status("midrst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
